div_32bit_seq: RTL and testbench

- Sequential signed 32-bit integer divider; the inverse operation to the datapath's combinational Booth multiplier.
- Produces a quotient and a remainder from a dividend and divisor using a restoring algorithm, one quotient bit per clock.
- Sits beside the multiplier in the ALU. Quotient feeds LO and remainder feeds HI, giving the same 64-bit result pairing as the multiplier's product.
- Uses a start/busy/done handshake, so the control unit stalls while the divider is busy.

---
 rtl/div_32bit_seq_if.sv | 24 ++
 rtl/div_32bit_seq.sv | 140 ++++++++++++++
 tb/tb_div_32bit_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_32bit_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
// The control side uses the master modport and the divider uses the slave modport.
interface div_32bit_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_32bit_seq.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Quotient goes to LO and remainder to HI, mirroring the multiplier's product.
// Optional feature macro: DIV_ZERO_DETECT_EN (zero-divisor short cut and div_zero flag).
// Without it the divide-by-zero case runs the normal algorithm and div_zero is 0.
module div_32bit_seq #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             clr,
  div_32bit_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t           state_reg;
  logic             sign_dd_reg;
  logic             sign_dv_reg;
  logic [WIDTH-1:0] mag_dv_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]    count_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
`ifdef DIV_ZERO_DETECT_EN
  logic             zero_reg;
  logic             div_zero_reg;
`endif

  logic [WIDTH-1:0] dd_abs;
  logic [WIDTH-1:0] dv_abs;
  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes, one restoring trial subtract, and the final sign fix-up.
  // |-2^(WIDTH-1)| wraps to the same bit pattern, which is its correct unsigned magnitude.
  always_comb begin
    dd_abs   = bus.dividend[WIDTH-1] ? ('0 - bus.dividend) : bus.dividend;
    dv_abs   = bus.divisor[WIDTH-1]  ? ('0 - bus.divisor)  : bus.divisor;
    r_shift  = {r_reg, q_reg[WIDTH-1]};
    diff     = r_shift - {2'b00, mag_dv_reg};
    quot_fix = (sign_dd_reg ^ sign_dv_reg) ? ('0 - q_reg) : q_reg;
    rem_fix  = sign_dd_reg ? ('0 - r_reg[WIDTH-1:0]) : r_reg[WIDTH-1:0];
  end

  // Control FSM and datapath registers; clr aborts any operation immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg     <= IDLE;
      sign_dd_reg   <= 1'b0;
      sign_dv_reg   <= 1'b0;
      mag_dv_reg    <= '0;
      r_reg         <= '0;
      q_reg         <= '0;
      count_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
`ifdef DIV_ZERO_DETECT_EN
      zero_reg      <= 1'b0;
      div_zero_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            sign_dd_reg <= bus.dividend[WIDTH-1];
            sign_dv_reg <= bus.divisor[WIDTH-1];
            mag_dv_reg  <= dv_abs;
            q_reg       <= dd_abs;
            r_reg       <= '0;
            count_reg   <= CW'(WIDTH - 1);
            busy_reg    <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
            zero_reg    <= (bus.divisor == '0);
            state_reg   <= (bus.divisor == '0) ? FIX : DIV;
`else
            state_reg   <= DIV;
`endif
          end
        end
        DIV: begin
          // Keep the trial difference when it did not go negative.
          if (diff[WIDTH+1]) begin
            r_reg <= r_shift[WIDTH:0];
          end else begin
            r_reg <= diff[WIDTH:0];
          end
          q_reg <= {q_reg[WIDTH-2:0], ~diff[WIDTH+1]};
          if (count_reg == '0) begin
            state_reg <= FIX;
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        FIX: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
`ifdef DIV_ZERO_DETECT_EN
          div_zero_reg <= zero_reg;
          if (zero_reg) begin
            // DIV was skipped, so q_reg still holds |dividend|.
            quotient_reg  <= '1;
            remainder_reg <= sign_dd_reg ? ('0 - q_reg) : q_reg;
          end else begin
            quotient_reg  <= quot_fix;
            remainder_reg <= rem_fix;
          end
`else
          quotient_reg  <= quot_fix;
          remainder_reg <= rem_fix;
`endif
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
`ifdef DIV_ZERO_DETECT_EN
  assign bus.div_zero  = div_zero_reg;
`else
  assign bus.div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_div_32bit_seq.sv
// Scoreboard bench for div_32bit_seq: expected results are queued when an
// operation is started and compared when done pulses.
module tb_div_32bit_seq;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  logic clk;
  logic clr;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  div_32bit_seq_if #(.WIDTH(32)) bus ();

  div_32bit_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: C-style signed division, written independently of the algorithm.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa;
    int   sb_v;
    sa   = a;
    sb_v = b;
    e.dz  = 1'b0;
    e.lat = 33;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_DETECT_EN
      e.q   = 32'hFFFF_FFFF;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 1;  // accept edge goes straight to FIX; the next edge completes
`else
      e.q   = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
      e.r   = a;
`endif
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else begin
      e.q = sa / sb_v;
      e.r = sa % sb_v;
    end
    return e;
  endfunction

  // Drive a start request at the current negedge and queue its expectation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    sb.push_back(model(a, b));
  endtask

  // Wait (bounded) for done; optionally re-pulse start with junk operands at edge pulse_at.
  task automatic wait_done(input int pulse_at, output int edges, output int busy_cnt,
                           output bit got);
    got      = 1'b0;
    edges    = 0;
    busy_cnt = 0;
    while (!got && edges < 100) begin
      @(negedge clk);
      edges++;
      bus.start = 1'b0;
      if (edges == pulse_at) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd7;
        bus.divisor  = 32'd7;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    clr       = 1'b1;
    bus.start = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", bus.done); end
    n_cmp++; if (bus.quotient !== 32'd0) begin n_bad++; $display("FAIL reset quotient: got %h want 0", bus.quotient); end
    n_cmp++; if (bus.remainder !== 32'd0) begin n_bad++; $display("FAIL reset remainder: got %h want 0", bus.remainder); end
    n_cmp++; if (bus.div_zero !== 1'b0) begin n_bad++; $display("FAIL reset div_zero: got %b want 0", bus.div_zero); end
    clr = 1'b0;
    @(negedge clk);
    $display("reset released");
  endtask

  // Several sign/boundary combinations, each run start-to-done and scored.
  task automatic test_ops(input string name, input logic [31:0] as [], input logic [31:0] bs []);
    int   edges;
    int   busy_cnt;
    bit   got;
    exp_t e;
    for (int i = 0; i < as.size(); i++) begin
      issue(as[i], bs[i]);
      wait_done(0, edges, busy_cnt, got);
      e = sb.pop_front();
      $display("%s: %h / %h -> q=%h r=%h dz=%b edges=%0d", name, as[i], bs[i],
               bus.quotient, bus.remainder, bus.div_zero, edges - 1);
      n_cmp++; if (!got) begin n_bad++; $display("FAIL %s done: got timeout want pulse", name); end
      n_cmp++; if (edges - 1 !== e.lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", name, edges - 1, e.lat); end
      n_cmp++; if (busy_cnt !== e.lat) begin n_bad++; $display("FAIL %s busy cycles: got %0d want %0d", name, busy_cnt, e.lat); end
      n_cmp++; if (bus.quotient !== e.q) begin n_bad++; $display("FAIL %s quotient: got %h want %h", name, bus.quotient, e.q); end
      n_cmp++; if (bus.remainder !== e.r) begin n_bad++; $display("FAIL %s remainder: got %h want %h", name, bus.remainder, e.r); end
      n_cmp++; if (bus.div_zero !== e.dz) begin n_bad++; $display("FAIL %s div_zero: got %b want %b", name, bus.div_zero, e.dz); end
    end
  endtask

  task automatic test_ignore_start();
    int   edges;
    int   busy_cnt;
    bit   got;
    int   extra;
    exp_t e;
    issue(32'd50, 32'd5);
    wait_done(10, edges, busy_cnt, got);
    e = sb.pop_front();
    $display("ignore_start: 50 / 5 -> q=%0d r=%0d edges=%0d", bus.quotient, bus.remainder, edges - 1);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL ignore done: got timeout want pulse"); end
    n_cmp++; if (edges - 1 !== e.lat) begin n_bad++; $display("FAIL ignore latency: got %0d want %0d", edges - 1, e.lat); end
    n_cmp++; if (bus.quotient !== e.q) begin n_bad++; $display("FAIL ignore quotient: got %h want %h", bus.quotient, e.q); end
    n_cmp++; if (bus.remainder !== e.r) begin n_bad++; $display("FAIL ignore remainder: got %h want %h", bus.remainder, e.r); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL ignore extra done: got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int   edges;
    int   busy_cnt;
    bit   got;
    exp_t e;
    logic [31:0] as [2];
    logic [31:0] bs [2];
    as = '{32'd50, 32'd9};
    bs = '{32'd5, 32'd4};
    for (int i = 0; i < 2; i++) begin
      // The second start lands in the done cycle of the first operation.
      issue(as[i], bs[i]);
      wait_done(0, edges, busy_cnt, got);
      e = sb.pop_front();
      $display("back_to_back: %0d / %0d -> q=%0d r=%0d cycles=%0d", as[i], bs[i],
               bus.quotient, bus.remainder, edges);
      n_cmp++; if (!got) begin n_bad++; $display("FAIL b2b done: got timeout want pulse"); end
      n_cmp++; if (edges !== 34) begin n_bad++; $display("FAIL b2b period: got %0d want 34", edges); end
      n_cmp++; if (bus.quotient !== e.q) begin n_bad++; $display("FAIL b2b quotient: got %h want %h", bus.quotient, e.q); end
      n_cmp++; if (bus.remainder !== e.r) begin n_bad++; $display("FAIL b2b remainder: got %h want %h", bus.remainder, e.r); end
    end
  endtask

  task automatic test_clr_abort();
    int   edges;
    int   busy_cnt;
    bit   got;
    int   seen;
    exp_t e;
    issue(32'd1000, 32'd3);
    repeat (15) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    clr = 1'b1;
    #1;
    e = sb.pop_front();  // aborted operation never completes
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL clr busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.quotient !== 32'd0) begin n_bad++; $display("FAIL clr quotient: got %h want 0", bus.quotient); end
    n_cmp++; if (bus.remainder !== 32'd0) begin n_bad++; $display("FAIL clr remainder: got %h want 0", bus.remainder); end
    @(negedge clk);
    clr  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    $display("clr_abort: aborted 1000 / 3 at cycle 15, activity after abort=%0d", seen);
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL clr aborted activity: got %0d want 0", seen); end
    issue(32'd1000, 32'd3);
    wait_done(0, edges, busy_cnt, got);
    e = sb.pop_front();
    $display("clr_abort: rerun 1000 / 3 -> q=%0d r=%0d", bus.quotient, bus.remainder);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL clr rerun done: got timeout want pulse"); end
    n_cmp++; if (bus.quotient !== e.q) begin n_bad++; $display("FAIL clr rerun quotient: got %h want %h", bus.quotient, e.q); end
    n_cmp++; if (bus.remainder !== e.r) begin n_bad++; $display("FAIL clr rerun remainder: got %h want %h", bus.remainder, e.r); end
  endtask

  task automatic test_random();
    logic [31:0] as [6];
    logic [31:0] bs [6];
    for (int i = 0; i < 6; i++) begin
      as[i] = $urandom;
      bs[i] = $urandom_range(1, 1000);
      if ($urandom_range(0, 1) == 1) bs[i] = 32'd0 - bs[i];
    end
    test_ops("random", as, bs);
  endtask

  initial begin
    logic [31:0] as [];
    logic [31:0] bs [];
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    as = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C};
    bs = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    test_ops("signs", as, bs);
    as = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    bs = '{32'hFFFF_FFFF, 32'd1, 32'h8000_0000};
    test_ops("overflow", as, bs);
    test_ignore_start();
    test_back_to_back();
    test_clr_abort();
    as = '{32'hFFFF_FFFB, 32'd12};
    bs = '{32'd0, 32'd0};
    test_ops("div_zero", as, bs);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
